multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Parametrised control FSM for the multicycle ARM-subset core.
//  - Sequences FETCH/DECODE/EXEC/MEM/WB with ready handshakes to instruction and data memory.
//  - Owns the PC and the NZCV flags; evaluates condition codes; computes branch targets and link values.
//  - Asserts datapath enables for the regfile, memory and ALU. Sits between memories, reg_file and alu.
// PARAMETERS
//  ADDR_W      32  PC / data width
//  REG_AW      4   register address width
//  PC_REG      15  register index treated as PC
//  LINK_REG    14  register written by BL
//  MEM_TIMEOUT 15  max wait cycles for imem/dmem ready before FAULT
// PORTS
//  clk         in   1       clock
//  nreset      in   1       reset; synchronous, active-low
//  imem_req    out  1       fetch request, held until imem_ready
//  imem_ready  in   1       fetch data valid this cycle
//  imem_rdata  in   32      instruction word
//  dmem_req    out  1       load/store request, held until dmem_ready
//  dmem_we     out  1       1=store, 0=load; valid while dmem_req
//  dmem_ready  in   1       data access complete this cycle
//  alu_flags   in   4       NZCV produced by ALU for current ir
//  wb_data     in   ADDR_W  datapath writeback value (ALU or load data)
//  pc          out  ADDR_W  registered program counter
//  ir          out  32      latched instruction
//  rf_re       out  1       regfile read enable
//  rf_we       out  1       regfile write enable (1-cycle pulse)
//  rf_waddr    out  REG_AW  write address
//  rf_wsel     out  2       0=ALU, 1=MEM, 2=LINK (pc+4)
//  link_data   out  ADDR_W  pc+4, valid when rf_wsel=2
//  flags       out  4       registered NZCV
//  state       out  3       0 FETCH,1 DECODE,2 EXEC,3 MEM,4 WB,5 FAULT
//  retired     out  1       1-cycle pulse when an instruction completes or is skipped
//  fault       out  1       high in FAULT
// BEHAVIOUR
//  Reset (nreset=0 at posedge): pc=0, ir=0, flags=0, state=FETCH, every strobe/enable=0, timeout counter=0.
//  Reset wins over any state, including a pending request.
//  Decode of ir:
//    ir[27:26]=00 ALU; 01 LDR/STR (L=ir[20]); 10 B/BL (link=ir[24]); 11 FAULT.
//    rd=ir[15:12]. S=ir[20].
//  Conditions:
//    cond=ir[31:28] is evaluated on flags with the standard ARM EQ..LE set.
//    1110 (AL) passes; 1111 never passes.
//  FETCH: imem_req=1 and pc stable. On imem_ready: ir<=imem_rdata, go to DECODE.
//  DECODE: rf_re=1 for one cycle.
//    Condition fails: pc<=pc+4, retired, go to FETCH.
//    Class 11: go to FAULT.
//    Otherwise: go to EXEC.
//  EXEC:
//    ALU: if S, flags<=alu_flags. Opcodes ir[24:21]=10xx (TST/TEQ/CMP/CMN) have no writeback: pc+4, retired, go to FETCH. All other ALU ops go to WB.
//    Branch: target = pc+8+(sign_ext(ir[23:0])<<2), mod 2^ADDR_W. If link: rf_we=1, rf_waddr=LINK_REG, rf_wsel=2. Then pc<=target, retired, go to FETCH.
//    LDR/STR: go to MEM.
//  MEM: dmem_req=1, dmem_we=~L.
//    On dmem_ready: load goes to WB; store does pc+4, retired, go to FETCH.
//  WB: rf_waddr=rd, rf_wsel = 1 for load, 0 for ALU.
//    rd==PC_REG: rf_we=0, pc<=wb_data.
//    Otherwise: rf_we=1, pc<=pc+4. Then retired, go to FETCH.
//  Handshakes:
//    Requests stay high until ready. Ready is ignored while its request is low.
//    The counter increments each waiting cycle and clears on ready.
//    Counter reaching MEM_TIMEOUT without ready: go to FAULT.
//    Ready on the same cycle as the timeout: ready wins.
//  FAULT: all requests and enables 0; fault=1; only nreset exits.
//  Latencies (zero-wait memory), clk from entering FETCH to retired:
//    condition fail 2; branch 3; compare 3; ALU 4; store 4; load 5.
//  pc wraps modulo 2^ADDR_W. Bits [1:0] of target and wb_data are passed through unmodified.
// TESTING
//  T1 reset:
//    Hold nreset=0 for 2 clk mid-MEM.
//    -> pc=0, state=0, dmem_req=0, flags=0.
//  T2 ALU:
//    Zero-wait; ir=E2811005 (ADD r1,r1,#5).
//    -> retired at cycle 4; rf_we pulse with waddr=1, wsel=0; pc=4.
//  T3 BL:
//    pc=0x100; ir=EBFFFFFE.
//    -> rf_we to r14 with link_data=0x104; pc=0x100.
//  T4 conditional skip:
//    flags Z=0; ir=0A000010 (BEQ).
//    -> retired after 2 clk; pc+=4; no rf_we.
//  T5 load with wait states:
//    3 wait states on dmem, LDR r2.
//    -> dmem_req held 4 cycles; rf_we with wsel=1; retired at cycle 8.
//  T6 timeout:
//    imem_ready never asserted.
//    -> FAULT after MEM_TIMEOUT cycles; fault=1 persists until nreset.
//    Also, ready on the timeout cycle -> normal DECODE.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Control FSM for the multicycle ARM-subset core. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, owns the PC and NZCV flags, evaluates
// condition codes, forms branch targets and link values, and drives the
// regfile / memory strobes. All outputs are registered; strobes are
// computed from the next state so they line up with the state they belong to.
module multicycle_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 4,
    parameter int PC_REG      = 15,
    parameter int LINK_REG    = 14,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              nreset,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic [3:0]        alu_flags,
    input  logic [ADDR_W-1:0] wb_data,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic              rf_re,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [1:0]        rf_wsel,
    output logic [ADDR_W-1:0] link_data,
    output logic [3:0]        flags,
    output logic [2:0]        state,
    output logic              retired,
    output logic              fault
);

    // Wait counter must be able to hold MEM_TIMEOUT-1 (the last legal wait count).
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    localparam logic [REG_AW-1:0] PC_IDX   = REG_AW'(PC_REG);
    localparam logic [REG_AW-1:0] LINK_IDX = REG_AW'(LINK_REG);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_LS  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_MEM  = 2'd1;
    localparam logic [1:0] WSEL_LINK = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    // Standard ARM condition evaluation on NZCV; 1111 never executes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic ok;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'h0:    ok = z;
            4'h1:    ok = ~z;
            4'h2:    ok = c;
            4'h3:    ok = ~c;
            4'h4:    ok = n;
            4'h5:    ok = ~n;
            4'h6:    ok = v;
            4'h7:    ok = ~v;
            4'h8:    ok = c & ~z;
            4'h9:    ok = ~c | z;
            4'hA:    ok = (n == v);
            4'hB:    ok = (n != v);
            4'hC:    ok = ~z & (n == v);
            4'hD:    ok = z | (n != v);
            4'hE:    ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Branch target: pc + 8 + sign-extended word offset, wrapping at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] base,
                                                        input logic [23:0] imm);
        logic [ADDR_W-1:0] off;
        off = {{(ADDR_W - 26){imm[23]}}, imm, 2'b00};
        return base + ADDR_W'(32'd8) + off;
    endfunction

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [31:0]       ir_q,        ir_d;
    logic [3:0]        flags_q,     flags_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              imem_req_q,  imem_req_d;
    logic              dmem_req_q,  dmem_req_d;
    logic              dmem_we_q,   dmem_we_d;
    logic              rf_re_q,     rf_re_d;
    logic              rf_we_q,     rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q,  rf_waddr_d;
    logic [1:0]        rf_wsel_q,   rf_wsel_d;
    logic [ADDR_W-1:0] link_data_q, link_data_d;
    logic              retired_q,   retired_d;
    logic              fault_q,     fault_d;

    // Instruction fields of the latched instruction.
    logic [1:0]        cls_s;
    logic [REG_AW-1:0] rd_s;
    logic              s_bit_s;
    logic              is_load_s;
    logic              link_s;
    logic              no_wb_s;
    logic              rd_is_pc_s;
    logic              cond_ok_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] target_s;

    assign cls_s      = ir_q[27:26];
    assign rd_s       = REG_AW'(ir_q[15:12]);
    assign s_bit_s    = ir_q[20];
    assign is_load_s  = ir_q[20];
    assign link_s     = ir_q[24];
    assign no_wb_s    = (ir_q[24:23] == 2'b10);
    assign rd_is_pc_s = (rd_s == PC_IDX);
    assign cond_ok_s  = cond_pass(ir_q[31:28], flags_q);
    assign pc_inc_s   = pc_q + PC_STEP;
    assign target_s   = branch_target(pc_q, ir_q[23:0]);

    // Next-state, PC/flags/IR updates and handshake wait counting.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH: begin
                // Request is registered, so the first cycle after reset has it low
                // and any ready is ignored there.
                if (imem_req_q) begin
                    if (imem_ready) begin
                        ir_d    = imem_rdata;
                        cnt_d   = '0;
                        state_d = S_DECODE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FAULT;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            S_DECODE: begin
                if (!cond_ok_s) begin
                    pc_d    = pc_inc_s;
                    state_d = S_FETCH;
                end else if (cls_s == 2'b11) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_s)
                    CLS_ALU: begin
                        if (s_bit_s) begin
                            flags_d = alu_flags;
                        end else begin
                            flags_d = flags_q;
                        end
                        if (no_wb_s) begin
                            pc_d    = pc_inc_s;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                    CLS_BR: begin
                        pc_d    = target_s;
                        state_d = S_FETCH;
                    end
                    CLS_LS: begin
                        state_d = S_MEM;
                    end
                    default: begin
                        state_d = S_FAULT;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_req_q) begin
                    if (dmem_ready) begin
                        cnt_d = '0;
                        if (is_load_s) begin
                            state_d = S_WB;
                        end else begin
                            pc_d    = pc_inc_s;
                            state_d = S_FETCH;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FAULT;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            S_WB: begin
                if (rd_is_pc_s) begin
                    pc_d = wb_data;
                end else begin
                    pc_d = pc_inc_s;
                end
                state_d = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Registered strobes derived from the state being entered.
    always_comb begin
        imem_req_d  = (state_d == S_FETCH);
        dmem_req_d  = (state_d == S_MEM);
        dmem_we_d   = (state_d == S_MEM) & ~ir_d[20];
        rf_re_d     = (state_d == S_DECODE);
        fault_d     = (state_d == S_FAULT);
        retired_d   = (state_q != S_FETCH) && (state_d == S_FETCH);
        link_data_d = pc_d + PC_STEP;
        rf_we_d     = 1'b0;
        rf_waddr_d  = '0;
        rf_wsel_d   = WSEL_ALU;
        if (state_d == S_WB) begin
            rf_we_d    = ~rd_is_pc_s;
            rf_waddr_d = rd_s;
            rf_wsel_d  = is_load_s && (cls_s == CLS_LS) ? WSEL_MEM : WSEL_ALU;
        end else if ((state_d == S_EXEC) && (cls_s == CLS_BR) && link_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = LINK_IDX;
            rf_wsel_d  = WSEL_LINK;
        end else begin
            rf_we_d    = 1'b0;
        end
    end

    // State, architectural registers and output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= 32'h0000_0000;
            flags_q     <= 4'h0;
            cnt_q       <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            rf_re_q     <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wsel_q   <= 2'd0;
            link_data_q <= '0;
            retired_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            rf_re_q     <= rf_re_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wsel_q   <= rf_wsel_d;
            link_data_q <= link_data_d;
            retired_q   <= retired_d;
            fault_q     <= fault_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign rf_re     = rf_re_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wsel   = rf_wsel_q;
    assign link_data = link_data_q;
    assign flags     = flags_q;
    assign state     = state_q;
    assign retired   = retired_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: an instruction-level model pushes
// expected regfile writes and retirements into queues; the DUT's rf_we and
// retired pulses pop and compare them.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        nreset;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic [3:0]  alu_flags;
    logic [31:0] wb_data;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        rf_re;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [1:0]  rf_wsel;
    logic [31:0] link_data;
    logic [3:0]  flags;
    logic [2:0]  state;
    logic        retired;
    logic        fault;

    multicycle_sequencer dut (
        .clk(clk), .nreset(nreset),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .alu_flags(alu_flags), .wb_data(wb_data),
        .pc(pc), .ir(ir), .rf_re(rf_re), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wsel(rf_wsel), .link_data(link_data), .flags(flags), .state(state),
        .retired(retired), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  waddr;
        logic [1:0]  wsel;
        logic [31:0] link;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        int          lat;
        logic [3:0]  flags;
    } rt_t;

    wr_t wr_q[$];
    rt_t rt_q[$];

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;
    logic [3:0]  exp_flags;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Condition model: ARM pairs conditions, the odd code is the inverse of the even one.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic base;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] && !f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = !f[2] && (f[3] == f[0]);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for two clocks, check reset state, then show ready is ignored while req is low.
    task automatic do_reset();
        nreset     = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_ir", ir, 32'h0);
        exp_pc     = 32'h0;
        exp_flags  = 4'h0;
        nreset     = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hE2811005;
        step();
        chk("rst_ready_ignored_state", {29'd0, state}, 32'd0);
        chk("rst_ready_ignored_ir", ir, 32'h0);
        chk("rst_req_up", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b0;
    endtask

    // Model one instruction, push expectations, then run the memories until retire.
    task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                             input logic [31:0] wbd, input logic [3:0] af);
        wr_t         w;
        rt_t         r;
        logic        pass;
        logic [1:0]  cls;
        logic [31:0] nxt;
        int          lat;
        int          exp_dreq;
        int          icnt;
        int          dcnt;
        int          dreq_cnt;
        int          cyc;
        bit          done;
        pass     = cond_ok(instr[31:28], exp_flags);
        cls      = instr[27:26];
        nxt      = exp_pc + 32'd4;
        exp_dreq = 0;
        lat      = 0;
        if (!pass) begin
            lat = 2;
        end else if (cls == 2'b10) begin
            lat = 3;
            nxt = exp_pc + 32'd8 + {{6{instr[23]}}, instr[23:0], 2'b00};
            if (instr[24]) begin
                w.waddr = 4'd14; w.wsel = 2'd2; w.link = exp_pc + 32'd4;
                wr_q.push_back(w);
            end
        end else if (cls == 2'b00) begin
            if (instr[20]) exp_flags = af;
            if (instr[24:23] == 2'b10) begin
                lat = 3;
            end else begin
                lat = 4;
                if (instr[15:12] == 4'd15) nxt = wbd;
                else begin
                    w.waddr = instr[15:12]; w.wsel = 2'd0; w.link = 32'h0;
                    wr_q.push_back(w);
                end
            end
        end else begin
            exp_dreq = dwait + 1;
            if (instr[20]) begin
                lat = 5 + dwait;
                if (instr[15:12] == 4'd15) nxt = wbd;
                else begin
                    w.waddr = instr[15:12]; w.wsel = 2'd1; w.link = 32'h0;
                    wr_q.push_back(w);
                end
            end else begin
                lat = 4 + dwait;
            end
        end
        r.pc = nxt; r.ir = instr; r.lat = lat + iwait; r.flags = exp_flags;
        rt_q.push_back(r);
        exp_pc = nxt;

        alu_flags  = af;
        wb_data    = wbd;
        imem_rdata = instr;
        icnt = 0; dcnt = 0; dreq_cnt = 0; cyc = 0; done = 0;
        while (!done && cyc < 60) begin
            imem_ready = imem_req && (icnt >= iwait);
            if (imem_req && !imem_ready) icnt++;
            dmem_ready = dmem_req && (dcnt >= dwait);
            if (dmem_req && !dmem_ready) dcnt++;
            step();
            cyc++;
            if (dmem_req) begin
                dreq_cnt++;
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, !instr[20]});
            end
            if (rf_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_rf_we", {31'd0, rf_we}, 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, w.waddr});
                    chk("rf_wsel", {30'd0, rf_wsel}, {30'd0, w.wsel});
                    if (w.wsel == 2'd2) chk("link_data", link_data, w.link);
                end
            end
            if (retired) begin
                done = 1;
                if (rt_q.size() == 0) begin
                    chk("unexpected_retire", {31'd0, retired}, 32'd0);
                end else begin
                    r = rt_q.pop_front();
                    chk("ret_pc", pc, r.pc);
                    chk("ret_ir", ir, r.ir);
                    chk("ret_latency", cyc, r.lat);
                    chk("ret_flags", {28'd0, flags}, {28'd0, r.flags});
                end
            end
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        chk("retired_seen", {31'd0, done}, 32'd1);
        if (exp_dreq != 0) chk("dmem_req_cycles", dreq_cnt, exp_dreq);
        chk("wr_q_empty", wr_q.size(), 0);
    endtask

    initial begin
        int          k;
        logic [31:0] off;
        logic        seen;
        imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = 32'h0;
        alu_flags  = 4'h0; wb_data = 32'h0; nreset = 1'b0;
        exp_pc = 32'h0; exp_flags = 4'h0;

        do_reset();
        run_instr(32'hE2811005, 0, 0, 32'h55, 4'h0);          // ADD r1,r1,#5
        run_instr(32'h0A000010, 0, 0, 32'h0, 4'h0);           // BEQ, Z=0: skipped
        run_instr(32'hE3510005, 0, 0, 32'h0, 4'b0100);        // CMP sets Z
        run_instr(32'h0A000010, 0, 0, 32'h0, 4'h0);           // BEQ taken -> 0x54
        off = (32'h100 - exp_pc - 32'd8) >> 2;
        run_instr({8'hEA, off[23:0]}, 0, 0, 32'h0, 4'h0);     // B to 0x100
        run_instr(32'hEBFFFFFE, 0, 0, 32'h0, 4'h0);           // BL to self, r14=0x104
        run_instr(32'hE5812000, 0, 0, 32'h0, 4'h0);           // STR r2,[r1]
        run_instr(32'hE5912000, 0, 3, 32'hABCD, 4'h0);        // LDR r2 with 3 waits
        run_instr(32'hE281F000, 0, 0, 32'hFFFFFFFE, 4'h0);    // write to pc, low bits kept
        run_instr(32'hE2811005, 0, 0, 32'h77, 4'h0);          // pc wraps to 0x2
        run_instr(32'h12811005, 1, 0, 32'h77, 4'h0);          // ADDNE with Z=1: skipped

        // Reset while an LDR is parked in MEM.
        imem_rdata = 32'hE5912000;
        seen = 1'b0;
        for (k = 0; k < 20 && !seen; k++) begin
            imem_ready = imem_req;
            step();
            seen = (state == 3'd3);
        end
        imem_ready = 1'b0;
        step();
        chk("mid_mem_req", {31'd0, dmem_req}, 32'd1);
        do_reset();

        // Class 11 instruction traps into FAULT, which ignores further readies.
        imem_rdata = 32'hEC000000;
        seen = 1'b0;
        for (k = 0; k < 10 && !seen; k++) begin
            imem_ready = imem_req;
            step();
            seen = (state == 3'd5);
        end
        chk("fault_state", {29'd0, state}, 32'd5);
        chk("fault_flag", {31'd0, fault}, 32'd1);
        chk("fault_imem_req", {31'd0, imem_req}, 32'd0);
        chk("fault_rf_re", {31'd0, rf_re}, 32'd0);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) step();
        chk("fault_sticky", {29'd0, state}, 32'd5);
        do_reset();

        // Fetch timeout: no ready for MEM_TIMEOUT request cycles.
        repeat (14) step();
        chk("to_not_yet", {29'd0, state}, 32'd0);
        step();
        chk("to_state", {29'd0, state}, 32'd5);
        chk("to_fault", {31'd0, fault}, 32'd1);
        imem_ready = 1'b1;
        repeat (4) step();
        chk("to_fault_persist", {31'd0, fault}, 32'd1);
        do_reset();

        // Ready on the timeout cycle wins; twice in a row shows the counter clears.
        run_instr(32'h0A000000, 14, 0, 32'h0, 4'h0);
        run_instr(32'h0A000000, 14, 0, 32'h0, 4'h0);
        chk("rt_q_empty", rt_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
